// File: rtl/load_fsm.sv
// load_fsm -- Moore control sequencer for the LOAD instruction.
//
// Read-direction counterpart of the store sequencer. It drives the selected
// address-source register onto the bus into MAR, holds the memory enable
// for MEM_LAT read cycles, captures the memory data into MDR, and then
// drives MDR onto the bus into the selected destination register.
//
// Parameters:
//   MEM_LAT       memory read latency in cycles (1..15), the number of READ cycles
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   start         LOAD decoded; held high by the controller until done
//   donefetch     instruction fetch complete; only looked at in WAITF
//   parameter1    destination select, one-hot R0..R3 in bits 3:0 (bits 5:4 invalid)
//   parameter2    address-source select, one-hot R0..R3,P0 in bits 4:0 (bit 5 invalid)
//   R0OutEn..P0OutEn  address-source register drives the bus (ADDR cycle)
//   R0InEn..R3InEn    destination register loads from the bus (WRITE cycle)
//   MARin         MAR loads from the bus
//   MDR_frommemin MDR loads from memory read data
//   MDR_tobusout  MDR drives the bus
//   EN            memory enable
//   RW            memory direction, 1 = write; this block only ever reads
//   done          instruction complete
//   err           invalid select code seen; valid together with done
//   P0inc         (only with LOAD_POSTINC_EN) post-increment P0 in WRITE
//
// Build option:
//   LOAD_POSTINC_EN  adds the P0inc output. Without it the port is absent
//                    and behaviour is otherwise identical.
//
// Every output is decoded from the registered state and the latched selects
// only, so there is no combinational path from any input to any output.

module load_fsm #(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       donefetch,
  input  logic [5:0] parameter1,
  input  logic [5:0] parameter2,
  output logic       R0OutEn,
  output logic       R1OutEn,
  output logic       R2OutEn,
  output logic       R3OutEn,
  output logic       P0OutEn,
  output logic       R0InEn,
  output logic       R1InEn,
  output logic       R2InEn,
  output logic       R3InEn,
  output logic       MARin,
  output logic       MDR_frommemin,
  output logic       MDR_tobusout,
  output logic       EN,
  output logic       RW,
  output logic       done,
  output logic       err
`ifdef LOAD_POSTINC_EN
  ,
  output logic       P0inc
`endif
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WAITF   = 3'd1;
  localparam logic [2:0] ADDR    = 3'd2;
  localparam logic [2:0] READ    = 3'd3;
  localparam logic [2:0] CAPTURE = 3'd4;
  localparam logic [2:0] WRITE   = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  // Last value of the READ counter; READ lasts MEM_LAT cycles (0..MEM_LAT-1).
  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [3:0] cnt;
  logic [3:0] dst_sel;
  logic [4:0] src_sel;
  logic       err_flag;

  logic       dst_ok;
  logic       src_ok;
  logic       sel_ok;
  logic       fetch_hit;

  // True when v has exactly one bit set.
  function automatic logic is_onehot(input logic [4:0] v);
    return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
  endfunction

  // Select codes are only valid when the unused high bits are clear and the
  // remaining bits are exactly one-hot.
  assign dst_ok = (parameter1[5:4] == 2'b00) && is_onehot({1'b0, parameter1[3:0]});
  assign src_ok = (parameter2[5] == 1'b0) && is_onehot(parameter2[4:0]);
  assign sel_ok = dst_ok && src_ok;

  // A dropped start in WAITF aborts, so the latch/launch only happens while
  // start is still asserted.
  assign fetch_hit = (state == WAITF) && start && donefetch;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = WAITF;
        end
      end
      WAITF: begin
        if (!start) begin
          state_nxt = IDLE;
        end else if (donefetch) begin
          state_nxt = sel_ok ? ADDR : DONE;
        end
      end
      ADDR: begin
        state_nxt = READ;
      end
      READ: begin
        if (cnt == LAT_LAST) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        state_nxt = WRITE;
      end
      WRITE: begin
        state_nxt = DONE;
      end
      DONE: begin
        if (!start) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      dst_sel  <= 4'd0;
      src_sel  <= 5'd0;
      err_flag <= 1'b0;
    end else begin
      state <= state_nxt;

      // The counter only runs in READ and is parked at zero elsewhere, so it
      // is already cleared when the next READ begins.
      if ((state == READ) && (cnt != LAT_LAST)) begin
        cnt <= cnt + 4'd1;
      end else begin
        cnt <= 4'd0;
      end

      if (fetch_hit) begin
        dst_sel  <= parameter1[3:0];
        src_sel  <= parameter2[4:0];
        err_flag <= !sel_ok;
      end else if ((state == DONE) && !start) begin
        dst_sel  <= 4'd0;
        src_sel  <= 5'd0;
        err_flag <= 1'b0;
      end
    end
  end

  // Output decode. Because the selects were checked one-hot before leaving
  // WAITF, at most one driver and one loader can be high in any cycle.
  always_comb begin
    R0OutEn       = 1'b0;
    R1OutEn       = 1'b0;
    R2OutEn       = 1'b0;
    R3OutEn       = 1'b0;
    P0OutEn       = 1'b0;
    R0InEn        = 1'b0;
    R1InEn        = 1'b0;
    R2InEn        = 1'b0;
    R3InEn        = 1'b0;
    MARin         = 1'b0;
    MDR_frommemin = 1'b0;
    MDR_tobusout  = 1'b0;
    EN            = 1'b0;
    RW            = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    case (state)
      ADDR: begin
        R0OutEn = src_sel[0];
        R1OutEn = src_sel[1];
        R2OutEn = src_sel[2];
        R3OutEn = src_sel[3];
        P0OutEn = src_sel[4];
        MARin   = 1'b1;
      end
      READ: begin
        EN = 1'b1;
      end
      CAPTURE: begin
        EN            = 1'b1;
        MDR_frommemin = 1'b1;
      end
      WRITE: begin
        MDR_tobusout = 1'b1;
        R0InEn       = dst_sel[0];
        R1InEn       = dst_sel[1];
        R2InEn       = dst_sel[2];
        R3InEn       = dst_sel[3];
      end
      DONE: begin
        done = 1'b1;
        err  = err_flag;
      end
      default: begin
      end
    endcase
  end

`ifdef LOAD_POSTINC_EN
  // P0 used as the address pointer steps forward once the load has landed.
  always_comb begin
    P0inc = (state == WRITE) && src_sel[4];
  end
`endif

endmodule

// File: tb/tb_load_fsm.sv
// tb_load_fsm -- self-checking bench for load_fsm.
//
// Two instances run side by side on the same inputs, one with MEM_LAT=1 and
// one with MEM_LAT=3. Expected outputs come from a timeline model: for a
// transaction whose donefetch edge is E, the model says what every output
// must be in cycle E+k purely from k, the latency and the select codes.
// Inputs change and outputs are sampled on the falling clock edge.
// Build option: LOAD_POSTINC_EN (adds P0inc checks).

module tb_load_fsm;

  typedef struct packed {
    logic r0o, r1o, r2o, r3o, p0o;
    logic r0i, r1i, r2i, r3i;
    logic mar, mdrf, mdrt, en, rw;
    logic done, err, p0inc;
  } outv_t;

  typedef struct {
    string      name;
    logic [5:0] p1;
    logic [5:0] p2;
    logic [4:0] src;
    logic [3:0] dst;
    logic       bad;
    logic       early;
    int         hold;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       donefetch;
  logic [5:0] parameter1;
  logic [5:0] parameter2;
  wire [16:0] a1;
  wire [16:0] a3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  load_fsm #(.MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .donefetch(donefetch),
    .parameter1(parameter1), .parameter2(parameter2),
    .R0OutEn(a1[16]), .R1OutEn(a1[15]), .R2OutEn(a1[14]), .R3OutEn(a1[13]),
    .P0OutEn(a1[12]),
    .R0InEn(a1[11]), .R1InEn(a1[10]), .R2InEn(a1[9]), .R3InEn(a1[8]),
    .MARin(a1[7]), .MDR_frommemin(a1[6]), .MDR_tobusout(a1[5]),
    .EN(a1[4]), .RW(a1[3]), .done(a1[2]), .err(a1[1])
`ifdef LOAD_POSTINC_EN
    , .P0inc(a1[0])
`endif
  );

  load_fsm #(.MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .donefetch(donefetch),
    .parameter1(parameter1), .parameter2(parameter2),
    .R0OutEn(a3[16]), .R1OutEn(a3[15]), .R2OutEn(a3[14]), .R3OutEn(a3[13]),
    .P0OutEn(a3[12]),
    .R0InEn(a3[11]), .R1InEn(a3[10]), .R2InEn(a3[9]), .R3InEn(a3[8]),
    .MARin(a3[7]), .MDR_frommemin(a3[6]), .MDR_tobusout(a3[5]),
    .EN(a3[4]), .RW(a3[3]), .done(a3[2]), .err(a3[1])
`ifdef LOAD_POSTINC_EN
    , .P0inc(a3[0])
`endif
  );

`ifndef LOAD_POSTINC_EN
  assign a1[0] = 1'b0;
  assign a3[0] = 1'b0;
`endif

  // Decode the select codes straight from their meaning: each must carry a
  // single set bit and nothing in its invalid positions.
  function automatic void decodeSel(input logic [5:0] p1, input logic [5:0] p2,
                                    output logic [4:0] src, output logic [3:0] dst,
                                    output logic bad);
    bad = !(($countones(p1) == 1) && (p1[5:4] == 2'b00) &&
            ($countones(p2) == 1) && (p2[5] == 1'b0));
    src = p2[4:0];
    dst = p1[3:0];
  endfunction

  // Outputs in cycle E+k of a transaction; k<1 means not yet launched.
  function automatic outv_t expectedOutputs(input logic [4:0] src, input logic [3:0] dst,
                                            input logic bad, input int lat, input int k);
    outv_t e;
    e = '0;
    if (k < 1) return e;
    if (bad) begin
      e.done = 1'b1;
      e.err  = 1'b1;
      return e;
    end
    if (k == 1) begin
      e.r0o = src[0]; e.r1o = src[1]; e.r2o = src[2]; e.r3o = src[3]; e.p0o = src[4];
      e.mar = 1'b1;
    end else if (k <= lat + 1) begin
      e.en = 1'b1;
    end else if (k == lat + 2) begin
      e.en   = 1'b1;
      e.mdrf = 1'b1;
    end else if (k == lat + 3) begin
      e.mdrt = 1'b1;
      e.r0i = dst[0]; e.r1i = dst[1]; e.r2i = dst[2]; e.r3i = dst[3];
`ifdef LOAD_POSTINC_EN
      e.p0inc = src[4];
`endif
    end else begin
      e.done = 1'b1;
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic s, input logic df,
                               input logic [5:0] p1, input logic [5:0] p2);
    start      = s;
    donefetch  = df;
    parameter1 = p1;
    parameter2 = p2;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input outv_t act, input outv_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %05h, expected %05h", name, act, exp);
    end
  endtask

  task automatic checkBoth(input string name, input logic [4:0] src, input logic [3:0] dst,
                           input logic bad, input int k);
    checkOutput($sformatf("%s k=%0d L=1", name, k), outv_t'(a1),
                expectedOutputs(src, dst, bad, 1, k));
    checkOutput($sformatf("%s k=%0d L=3", name, k), outv_t'(a3),
                expectedOutputs(src, dst, bad, 3, k));
  endtask

  // One full LOAD, starting and ending idle at a falling edge.
  task automatic runTransaction(input vec_t v);
    applyStimulus(1'b1, v.early, 6'(v.early ? v.p1 : 6'h3f), 6'h3f);
    checkBoth({v.name, " waitf"}, v.src, v.dst, v.bad, 0);
    for (int h = 0; h < v.hold; h++) begin
      applyStimulus(1'b1, 1'b0, v.p1, v.p2);
      checkBoth({v.name, " hold"}, v.src, v.dst, v.bad, 0);
    end
    applyStimulus(1'b1, 1'b1, v.p1, v.p2);
    for (int k = 1; k <= 9; k++) begin
      checkBoth(v.name, v.src, v.dst, v.bad, k);
      if (k < 9) applyStimulus(1'b1, 1'($urandom), 6'($urandom), 6'($urandom));
    end
    applyStimulus(1'b0, 1'b0, 6'd0, 6'd0);
    checkBoth({v.name, " idle"}, v.src, v.dst, v.bad, 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[$];
    vec_t v;
    logic [5:0] p1;
    logic [5:0] p2;

    vecs.push_back('{"nominal",  6'b000100, 6'b000010, 5'b00010, 4'b0100, 1'b0, 1'b0, 0});
    vecs.push_back('{"p0src",    6'b000001, 6'b010000, 5'b10000, 4'b0001, 1'b0, 1'b0, 0});
    vecs.push_back('{"r0src",    6'b001000, 6'b000001, 5'b00001, 4'b1000, 1'b0, 1'b0, 1});
    vecs.push_back('{"earlydf",  6'b000010, 6'b001000, 5'b01000, 4'b0010, 1'b0, 1'b1, 0});
    vecs.push_back('{"earlyhld", 6'b000001, 6'b000100, 5'b00100, 4'b0001, 1'b0, 1'b1, 2});
    vecs.push_back('{"bad2hot",  6'b000110, 6'b000010, 5'b00010, 4'b0110, 1'b1, 1'b0, 0});
    vecs.push_back('{"baddst4",  6'b010000, 6'b000001, 5'b00001, 4'b0000, 1'b1, 1'b0, 0});
    vecs.push_back('{"badsrc5",  6'b000001, 6'b100000, 5'b00000, 4'b0001, 1'b1, 1'b0, 0});
    vecs.push_back('{"srczero",  6'b000001, 6'b000000, 5'b00000, 4'b0001, 1'b1, 1'b0, 0});
    vecs.push_back('{"dstzero",  6'b000000, 6'b000100, 5'b00100, 4'b0000, 1'b1, 1'b0, 0});
    vecs.push_back('{"src2hot",  6'b000010, 6'b010100, 5'b10100, 4'b0010, 1'b1, 1'b0, 0});

    // Power-on reset.
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 6'd0, 6'd0);
    applyStimulus(1'b0, 1'b0, 6'd0, 6'd0);
    checkBoth("reset", 5'd0, 4'd0, 1'b0, 0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 6'd0, 6'd0);
    checkBoth("post reset", 5'd0, 4'd0, 1'b0, 0);

    foreach (vecs[i]) runTransaction(vecs[i]);

    // Reset in the middle of READ.
    applyStimulus(1'b1, 1'b0, 6'd0, 6'd0);
    applyStimulus(1'b1, 1'b1, 6'b000100, 6'b000010);
    checkBoth("midrst", 5'b00010, 4'b0100, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 6'd0, 6'd0);
    checkBoth("midrst", 5'b00010, 4'b0100, 1'b0, 2);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 6'd0, 6'd0);
    checkBoth("midrst edge1", 5'd0, 4'd0, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 6'd0, 6'd0);
    checkBoth("midrst edge2", 5'd0, 4'd0, 1'b0, 0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 6'd0, 6'd0);
    checkBoth("midrst released", 5'd0, 4'd0, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 6'b000100, 6'b000010);
    checkBoth("midrst lone df", 5'd0, 4'd0, 1'b0, 0);

    // Early abort: start drops while waiting for fetch.
    applyStimulus(1'b1, 1'b0, 6'b000100, 6'b000010);
    checkBoth("abort waitf", 5'd0, 4'd0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 6'b000100, 6'b000010);
    checkBoth("abort idle", 5'd0, 4'd0, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 6'b000100, 6'b000010);
    checkBoth("abort df1", 5'd0, 4'd0, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 6'b000100, 6'b000010);
    checkBoth("abort df2", 5'd0, 4'd0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 6'd0, 6'd0);

    // Randomised transactions, biased towards valid one-hot codes.
    for (int n = 0; n < 30; n++) begin
      p1 = ($urandom_range(0, 2) != 0) ? 6'(1 << $urandom_range(0, 3)) : 6'($urandom);
      p2 = ($urandom_range(0, 2) != 0) ? 6'(1 << $urandom_range(0, 4)) : 6'($urandom);
      v.name  = $sformatf("rand%0d", n);
      v.p1    = p1;
      v.p2    = p2;
      decodeSel(p1, p2, v.src, v.dst, v.bad);
      v.early = 1'($urandom);
      v.hold  = int'($urandom_range(0, 2));
      runTransaction(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
